// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state encoding and the op decode helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic is_div;
    logic hi_rem;   // high product half for multiplies, remainder for divides
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    d.b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    d.is_div   = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    d.hi_rem   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
                 (op == OP_REM) || (op == OP_REMU);
    return d;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and mul_div_unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             flush;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] result;

  modport master (output valid, flush, op, in_a, in_b, input ready, busy, result);
  modport slave  (input valid, flush, op, in_a, in_b, output ready, busy, result);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring shift-subtract
// divider on the 2*WIDTH working register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] shreg_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, shreg[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, opnd} : '0);
    rem_sh = shreg[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd};
    // when ge holds the true difference is below the divisor, so WIDTH bits suffice
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      shreg_nxt = {(ge ? diff : rem_sh[WIDTH-1:0]), shreg[WIDTH-2:0], ge};
    end else begin
      shreg_nxt = {sum, shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit, one bit per cycle.
// Signed operand handling is built only when MULDIV_SIGNED_EN is defined.
//
// state   | meaning
// IDLE    | waiting for valid; operands latched on accept
// CALC    | WIDTH shift-add / shift-subtract iterations
// FIX     | sign correction and result select
// DONE    | ready pulse, result presented
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               hi_rem_q, hi_rem_d;
  logic [2*WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] step_out;
  logic [2*WIDTH-1:0] fix_full;
  logic [WIDTH-1:0]   fix_res;
  logic [WIDTH-1:0]   a_mag, b_mag;
  op_dec_t            dec_in;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;
`else
  logic unused_sign;
  assign unused_sign = ^{dec_in.a_signed, dec_in.b_signed};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .shreg     (shreg_q),
    .opnd      (opnd_q),
    .shreg_nxt (step_out)
  );

  assign dec_in = decode_op(bus.op);

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    a_neg = dec_in.a_signed & bus.in_a[WIDTH-1];
    b_neg = dec_in.b_signed & bus.in_b[WIDTH-1];
    a_mag = a_neg ? -bus.in_a : bus.in_a;
    b_mag = b_neg ? -bus.in_b : bus.in_b;
`else
    a_mag = bus.in_a;
    b_mag = bus.in_b;
`endif
  end

  // products negate across the full 2*WIDTH value, quotient/remainder per half
  always_comb begin
    fix_full = shreg_q;
`ifdef MULDIV_SIGNED_EN
    if (neg_q && !is_div_q) fix_full = -shreg_q;
`endif
    fix_res = hi_rem_q ? fix_full[2*WIDTH-1:WIDTH] : fix_full[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (neg_q && is_div_q) fix_res = -fix_res;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_rem_d = hi_rem_q;
    shreg_d  = shreg_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    ready_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.valid && !bus.flush) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          is_div_d = dec_in.is_div;
          hi_rem_d = dec_in.hi_rem;
          shreg_d  = {{WIDTH{1'b0}}, (dec_in.is_div ? a_mag : b_mag)};
          opnd_d   = dec_in.is_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
          // divide-by-zero quotient stays all-ones, so no sign for it
          if (dec_in.is_div) begin
            neg_d = dec_in.hi_rem ? a_neg : ((a_neg ^ b_neg) && (bus.in_b != '0));
          end else begin
            neg_d = a_neg ^ b_neg;
          end
`endif
        end
      end
      ST_CALC: begin
        shreg_d = step_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d  = ST_DONE;
        result_d = fix_res;
        ready_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      ready_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_rem_q <= 1'b0;
      shreg_q  <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_rem_q <= hi_rem_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule
